// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers used by the inverse MixColumns datapath.
package aes_pkg;

  typedef logic [127:0] state_t;
  typedef logic [31:0]  word_t;
  typedef logic [7:0]   byte_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fsm_state_t;

  localparam byte_t AES_POLY = 8'h1B;

  // Multiply by x modulo x^8 + x^4 + x^3 + x + 1.
  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic byte_t gmul9(input byte_t b);
    byte_t x8;
    x8 = xtime(xtime(xtime(b)));
    return x8 ^ b;
  endfunction

  function automatic byte_t gmul11(input byte_t b);
    byte_t x2, x8;
    x2 = xtime(b);
    x8 = xtime(xtime(x2));
    return x8 ^ x2 ^ b;
  endfunction

  function automatic byte_t gmul13(input byte_t b);
    byte_t x4, x8;
    x4 = xtime(xtime(b));
    x8 = xtime(x4);
    return x8 ^ x4 ^ b;
  endfunction

  function automatic byte_t gmul14(input byte_t b);
    byte_t x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

endpackage

// File: rtl/inv_mix_word.sv
// Combinational inverse MixColumns of one 32-bit column; row 0 is the top byte.
module inv_mix_word
  import aes_pkg::*;
(
  input  logic [31:0] in_word,
  output logic [31:0] out_word
);

  byte_t w_s0, w_s1, w_s2, w_s3;

  assign w_s0 = in_word[31:24];
  assign w_s1 = in_word[23:16];
  assign w_s2 = in_word[15:8];
  assign w_s3 = in_word[7:0];

  assign out_word = {
    gmul14(w_s0) ^ gmul11(w_s1) ^ gmul13(w_s2) ^ gmul9(w_s3),
    gmul14(w_s1) ^ gmul11(w_s2) ^ gmul13(w_s3) ^ gmul9(w_s0),
    gmul14(w_s2) ^ gmul11(w_s3) ^ gmul13(w_s0) ^ gmul9(w_s1),
    gmul14(w_s3) ^ gmul11(w_s0) ^ gmul13(w_s1) ^ gmul9(w_s2)
  };

endmodule

// File: rtl/inv_mix_columns_iter.sv
// Iterative InvMixColumns with valid/ready handshakes on both sides.
// Define INV_MIX_COLUMNS_PARALLEL_EN to transform all four columns in one cycle.
module inv_mix_columns_iter
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_bus,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_bus,
  output logic         busy
);

  fsm_state_t r_state;
  state_t     r_work;
  state_t     w_next_work;
  logic       r_out_valid;
  logic       r_busy;

`ifdef INV_MIX_COLUMNS_PARALLEL_EN
  for (genvar g = 0; g < 4; g++) begin : g_col
    inv_mix_word u_word (
      .in_word  (r_work[32*g +: 32]),
      .out_word (w_next_work[32*g +: 32])
    );
  end
`else
  logic [1:0] r_col;
  word_t      w_col_in;
  word_t      w_col_out;

  assign w_col_in = r_work[32*r_col +: 32];

  inv_mix_word u_word (
    .in_word  (w_col_in),
    .out_word (w_col_out)
  );

  always_comb begin
    w_next_work = r_work;
    w_next_work[32*r_col +: 32] = w_col_out;
  end
`endif

  // DONE accepts a new block on the same edge its result is taken.
  assign in_ready  = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
  assign out_valid = r_out_valid;
  assign out_bus   = r_work;
  assign busy      = r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_work      <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
`ifndef INV_MIX_COLUMNS_PARALLEL_EN
      r_col       <= 2'd0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_work  <= in_bus;
            r_state <= ST_RUN;
            r_busy  <= 1'b1;
`ifndef INV_MIX_COLUMNS_PARALLEL_EN
            r_col   <= 2'd0;
`endif
          end
        end
        ST_RUN: begin
          r_work <= w_next_work;
`ifdef INV_MIX_COLUMNS_PARALLEL_EN
          r_state     <= ST_DONE;
          r_out_valid <= 1'b1;
`else
          r_col <= r_col + 2'd1;
          if (r_col == 2'd3) begin
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
          end
`endif
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (in_valid) begin
              r_work  <= in_bus;
              r_state <= ST_RUN;
`ifndef INV_MIX_COLUMNS_PARALLEL_EN
              r_col   <= 2'd0;
`endif
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
